// File: rtl/pipelined_shifter_unit.sv
// pipelined_shifter_unit
//   Pipelined barrel shifter performing LSL, LSR, ASR or ROR on a WIDTH-bit
//   operand. The shift is split into STAGES = log2(WIDTH) registered stages.
//   Stage k shifts by 2^k when shift[k] is set. A valid/ready handshake is
//   provided on both sides. Without stalls, latency is STAGES cycles and
//   throughput is one beat per cycle.
//
// Ports
//   clk       rising-edge clock
//   reset     asynchronous, active-high reset
//   in_valid  input beat valid
//   in_ready  unit can accept a beat this cycle
//   a         operand (WIDTH bits)
//   shift     shift amount, 0..2*WIDTH-1 (STAGES+1 bits)
//   op        00 LSL, 01 LSR, 10 ASR, 11 ROR
//   out_valid result valid
//   out_ready consumer accepts result
//   y         shifted result (WIDTH bits)
//   carry     last bit shifted out; present only with SHIFTER_CARRY_OUT_EN
//
// Optional feature macro: SHIFTER_CARRY_OUT_EN

module pipelined_shifter_unit #(
  parameter  int unsigned WIDTH  = 32,
  localparam int unsigned STAGES = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  a,
  input  logic [STAGES:0]   shift,
  input  logic [1:0]        op,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  y
`ifdef SHIFTER_CARRY_OUT_EN
  ,
  output logic              carry
`endif
);

  typedef enum logic [1:0] {
    OP_LSL = 2'b00,
    OP_LSR = 2'b01,
    OP_ASR = 2'b10,
    OP_ROR = 2'b11
  } op_e;

  // Stage registers
  logic [WIDTH-1:0] dat_q [STAGES];
  op_e              op_q  [STAGES];
  logic [STAGES:0]  sh_q  [STAGES];
  logic             sgn_q [STAGES];
  logic             vld_q [STAGES];

  // Stage inputs (stage 0 from the ports, stage k from register k-1)
  logic [WIDTH-1:0] src_dat [STAGES];
  op_e              src_op  [STAGES];
  logic [STAGES:0]  src_sh  [STAGES];
  logic             src_sgn [STAGES];
  logic             src_vld [STAGES];
  logic [WIDTH-1:0] nxt_dat [STAGES];

  logic             stall;
  op_e              op_in;

  function automatic logic [WIDTH-1:0] stage_shift(
    input logic [WIDTH-1:0] d,
    input op_e              o,
    input logic             s,
    input int unsigned      n
  );
    logic [WIDTH-1:0] r;
    case (o)
      OP_LSL:  r = d << n;
      OP_LSR:  r = d >> n;
      OP_ASR:  r = ({WIDTH{s}} << (WIDTH - n)) | (d >> n);
      default: r = (d >> n) | (d << (WIDTH - n));
    endcase
    return r;
  endfunction

  assign op_in     = op_e'(op);
  assign out_valid = vld_q[STAGES-1];
  assign y         = dat_q[STAGES-1];
  assign stall     = out_valid && !out_ready;
  assign in_ready  = !stall;

  always_comb begin
    // Out-of-range LSL/LSR/ASR are resolved before stage 0 shifts; later
    // shifts of an all-zero or all-sign word leave it unchanged, so the low
    // shift bits can still be applied unconditionally. ROR ignores the MSB.
    src_dat[0] = a;
    if (shift[STAGES] && (op_in != OP_ROR)) begin
      src_dat[0] = (op_in == OP_ASR) ? {WIDTH{a[WIDTH-1]}} : '0;
    end
    src_op[0]  = op_in;
    src_sh[0]  = shift;
    src_sgn[0] = a[WIDTH-1];
    src_vld[0] = in_valid;
    for (int unsigned k = 1; k < STAGES; k++) begin
      src_dat[k] = dat_q[k-1];
      src_op[k]  = op_q[k-1];
      src_sh[k]  = sh_q[k-1];
      src_sgn[k] = sgn_q[k-1];
      src_vld[k] = vld_q[k-1];
    end
    for (int unsigned k = 0; k < STAGES; k++) begin
      nxt_dat[k] = src_sh[k][k]
                 ? stage_shift(src_dat[k], src_op[k], src_sgn[k], 32'd1 << k)
                 : src_dat[k];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        dat_q[k] <= '0;
        op_q[k]  <= OP_LSL;
        sh_q[k]  <= '0;
        sgn_q[k] <= 1'b0;
        vld_q[k] <= 1'b0;
      end
    end else if (!stall) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        vld_q[k] <= src_vld[k];
        // Payload only loads with a valid beat so y keeps its last result
        // across bubbles.
        if (src_vld[k]) begin
          dat_q[k] <= nxt_dat[k];
          op_q[k]  <= src_op[k];
          sh_q[k]  <= src_sh[k];
          sgn_q[k] <= src_sgn[k];
        end
      end
    end
  end

`ifdef SHIFTER_CARRY_OUT_EN
  logic cy_q    [STAGES];
  logic src_cy  [STAGES];
  logic nxt_cy  [STAGES];

  // Bit that leaves the word in a single stage shift by n. For ROR the bit
  // leaving the LSB end is the one that lands in the MSB.
  function automatic logic out_bit(
    input logic [WIDTH-1:0] d,
    input op_e              o,
    input int unsigned      n
  );
    return (o == OP_LSL) ? d[WIDTH - n] : d[n - 1];
  endfunction

  assign carry = cy_q[STAGES-1];

  always_comb begin
    // Each shifting stage overwrites the carry with its own outgoing bit,
    // so the last shifting stage leaves the overall last bit shifted out.
    src_cy[0] = 1'b0;
    if (shift[STAGES] && (op_in != OP_ROR)) begin
      if (op_in == OP_ASR) begin
        src_cy[0] = a[WIDTH-1];
      end else if (shift[STAGES-1:0] == '0) begin
        src_cy[0] = (op_in == OP_LSL) ? a[0] : a[WIDTH-1];
      end
    end
    for (int unsigned k = 1; k < STAGES; k++) begin
      src_cy[k] = cy_q[k-1];
    end
    for (int unsigned k = 0; k < STAGES; k++) begin
      nxt_cy[k] = src_sh[k][k] ? out_bit(src_dat[k], src_op[k], 32'd1 << k)
                               : src_cy[k];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        cy_q[k] <= 1'b0;
      end
    end else if (!stall) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        if (src_vld[k]) begin
          cy_q[k] <= nxt_cy[k];
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipelined_shifter_unit.sv
module tb_pipelined_shifter_unit;

  localparam int W = 4;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [S:0]   shift;
  logic [1:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] y;
`ifdef SHIFTER_CARRY_OUT_EN
  logic         carry;
`endif

  pipelined_shifter_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .shift     (shift),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y)
`ifdef SHIFTER_CARRY_OUT_EN
    ,
    .carry     (carry)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int n_out  = 0;

  typedef struct {
    logic [W-1:0] y;
    logic         cy;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [S:0]   sh;
    logic [1:0]   op;
    logic [W-1:0] y;
    logic         cy;
  } vec_t;

  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on the shift rules.
  function automatic exp_t model(input int av, input int sh, input int o);
    exp_t e;
    int   sign;
    int   sv;
    int   r;
    int   yy;
    int   cy;
    sign = (av >> (W - 1)) & 1;
    case (o)
      0: begin
        yy = (sh >= W) ? 0 : ((av << sh) & 15);
        cy = (sh == 0) ? 0 : (sh < W) ? ((av >> (W - sh)) & 1) : (sh == W) ? (av & 1) : 0;
      end
      1: begin
        yy = (sh >= W) ? 0 : (av >> sh);
        cy = (sh == 0) ? 0 : (sh < W) ? ((av >> (sh - 1)) & 1) : (sh == W) ? sign : 0;
      end
      2: begin
        sv = sign ? av - 16 : av;
        yy = (sh >= W) ? (sign ? 15 : 0) : ((sv >>> sh) & 15);
        cy = (sh == 0) ? 0 : (sh < W) ? ((av >> (sh - 1)) & 1) : sign;
      end
      default: begin
        r  = sh % W;
        yy = ((av >> r) | (av << (W - r))) & 15;
        cy = (r != 0) ? ((yy >> (W - 1)) & 1) : 0;
      end
    endcase
    e.y  = 4'(yy);
    e.cy = 1'(cy);
    return e;
  endfunction

  // Scoreboard: sampled on the falling edge, transfers happen at the next rise.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          check("unexpected_output", 32'(out_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("model_y", 32'(y), 32'(e.y));
`ifdef SHIFTER_CARRY_OUT_EN
          check("model_carry", 32'(carry), 32'(e.cy));
`endif
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(int'(a), int'(shift), int'(op)));
      end
    end
  end

  // Expects to be called at posedge+#1; returns at accept-edge+#1.
  task automatic send(input logic [W-1:0] av, input logic [S:0] sh, input logic [1:0] o);
    bit ok;
    ok = 1'b0;
    a = av; shift = sh; op = o; in_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      @(posedge clk);
    end
    #1;
    in_valid = 1'b0;
    if (!ok) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  vec_t tbl[16];
  int   cnt;
  int   first_i;
  int   last_i;
  int   stale;
  int   base_out;
  int   waited;

  initial begin
    tbl[0]  = '{4'b1011, 3'd1, 2'd0, 4'b0110, 1'b1};
    tbl[1]  = '{4'b1011, 3'd1, 2'd1, 4'b0101, 1'b1};
    tbl[2]  = '{4'b1011, 3'd1, 2'd2, 4'b1101, 1'b1};
    tbl[3]  = '{4'b1011, 3'd1, 2'd3, 4'b1101, 1'b1};
    tbl[4]  = '{4'b1000, 3'd5, 2'd0, 4'b0000, 1'b0};
    tbl[5]  = '{4'b1000, 3'd5, 2'd1, 4'b0000, 1'b0};
    tbl[6]  = '{4'b1000, 3'd5, 2'd2, 4'b1111, 1'b1};
    tbl[7]  = '{4'b1000, 3'd5, 2'd3, 4'b0100, 1'b0};
    tbl[8]  = '{4'b1000, 3'd0, 2'd2, 4'b1000, 1'b0};
    tbl[9]  = '{4'b1001, 3'd1, 2'd0, 4'b0010, 1'b1};
    tbl[10] = '{4'b1001, 3'd1, 2'd1, 4'b0100, 1'b1};
    tbl[11] = '{4'b1001, 3'd0, 2'd0, 4'b1001, 1'b0};
    tbl[12] = '{4'b0111, 3'd4, 2'd0, 4'b0000, 1'b1};
    tbl[13] = '{4'b0111, 3'd4, 2'd1, 4'b0000, 1'b0};
    tbl[14] = '{4'b0110, 3'd6, 2'd3, 4'b1001, 1'b1};
    tbl[15] = '{4'b1100, 3'd2, 2'd2, 4'b1111, 1'b0};

    reset = 1'b1; in_valid = 1'b0; a = '0; shift = '0; op = '0; out_ready = 1'b1;
    #1;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_y", 32'(y), 32'd0);
`ifdef SHIFTER_CARRY_OUT_EN
    check("reset_carry", 32'(carry), 32'd0);
`endif
    idle(2);
    reset = 1'b0;
    #1;
    check("post_reset_in_ready", 32'(in_ready), 32'd1);

    // Directed vectors with exact latency
    idle(1);
    foreach (tbl[i]) begin
      send(tbl[i].a, tbl[i].sh, tbl[i].op);
      check("tbl_early_valid", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      check("tbl_out_valid", 32'(out_valid), 32'd1);
      check("tbl_y", 32'(y), 32'(tbl[i].y));
`ifdef SHIFTER_CARRY_OUT_EN
      check("tbl_carry", 32'(carry), 32'(tbl[i].cy));
`endif
    end

    // Full-rate streaming
    idle(2);
    cnt = 0; first_i = -1; last_i = -1;
    fork
      begin
        for (int i = 0; i < 16; i++) send(4'(i), 3'd2, 2'd0);
      end
      begin
        for (int i = 0; i < 22; i++) begin
          @(negedge clk);
          if (out_valid) begin
            cnt++;
            if (first_i < 0) first_i = i;
            last_i = i;
          end
        end
      end
    join
    check("stream_count", 32'(cnt), 32'd16);
    check("stream_back_to_back", 32'(last_i - first_i), 32'd15);

    // Backpressure
    idle(2);
    base_out = n_out;
    out_ready = 1'b0;
    fork
      begin
        send(4'b0001, 3'd1, 2'd0);
        send(4'b0010, 3'd1, 2'd1);
        send(4'b0011, 3'd1, 2'd3);
      end
      begin
        repeat (3) @(negedge clk);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        repeat (2) @(negedge clk);
        check("bp_hold_valid", 32'(out_valid), 32'd1);
        check("bp_hold_y", 32'(y), 32'b0010);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    idle(5);
    check("bp_outputs", 32'(n_out - base_out), 32'd3);
    check("bp_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset while beats are in flight
    send(4'b0101, 3'd1, 2'd0);
    send(4'b0011, 3'd1, 2'd1);
    reset = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_y", 32'(y), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    stale = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (out_valid) stale++;
    end
    check("midrst_no_stale", 32'(stale), 32'd0);
    send(4'b0001, 3'd2, 2'd0);
    check("midrst_early_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("midrst_latency_valid", 32'(out_valid), 32'd1);
    check("midrst_y_after", 32'(y), 32'b0100);

    // Randomised traffic against the model
    idle(1);
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      a         = 4'($urandom_range(0, 15));
      shift     = 3'($urandom_range(0, 7));
      op        = 2'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    waited = 0;
    while (exp_q.size() != 0 && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    idle(1);
    check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    check("drain_out_valid", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/pipelined_shifter_unit.md
Name: pipelined_shifter_unit

Overview:
- Parametrised, pipelined successor to the combinational left logic shifter.
- Performs LSL, LSR, ASR or ROR on a WIDTH-bit operand.
- Decomposes the shift into log2(WIDTH) registered barrel stages, with a valid/ready handshake on input and output.
- Sits between the ALU operand mux and the result writeback, so the shifter no longer limits the ALU critical path.

Parameters:
- WIDTH, 32: operand/result width in bits; power of two, >= 4.
- STAGES, $clog2(WIDTH): number of barrel stages. Derived (localparam); not overridable.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  input beat valid
- in_ready  output  1  unit can accept a beat this cycle
- a  input  WIDTH  operand
- shift  input  STAGES+1  shift amount, 0..2*WIDTH-1
- op  input  2  00 LSL, 01 LSR, 10 ASR, 11 ROR
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- y  output  WIDTH  shifted result

Behaviour:
- Reset (async, active-high):
  - All stage valid bits, data and control registers clear to 0.
  - Outputs go to 0 immediately: out_valid=0, y=0.
  - in_ready=1 once reset deasserts.
- Transfer rules:
  - An input beat is accepted when in_valid && in_ready at a rising edge.
  - An output beat is consumed when out_valid && out_ready.
- Stall:
  - stall = out_valid && !out_ready.
  - in_ready = !stall.
  - While stall=1, every stage register holds. No bubble collapse is required.
- Pipeline and latency:
  - Stage k (k=0..STAGES-1) shifts by 2^k when shift[k]=1.
  - Each stage registers its data, op, shift and a valid bit.
  - Latency is exactly STAGES cycles from accept to out_valid when there are no stalls. Example: WIDTH=4 gives 2 cycles.
  - Throughput is 1 beat/cycle.
- Out-of-range amounts (shift[STAGES]=1, i.e. shift >= WIDTH), applied in stage 0:
  - LSL/LSR: result 0.
  - ASR: result all copies of a[WIDTH-1].
  - ROR: shift[STAGES] ignored (amount mod WIDTH).
- Per-op fill:
  - LSL: zero-fill LSBs.
  - LSR: zero-fill MSBs.
  - ASR: fill MSBs with the original sign bit, carried down the pipe.
  - ROR: bits leaving the LSB enter the MSB.
- shift=0: y=a for all ops.
- Bubbles: cycles with in_valid=0 propagate as invalid stages. y holds its last value while out_valid=0; the bench must not check y then.
- Simultaneous accept and consume in the same cycle is legal; no beat is lost or duplicated.
- Reset mid-operation: all in-flight beats are discarded. No result for them ever appears.
- Invariant: at most STAGES beats are in flight.

Optional Feature:
- Macro: SHIFTER_CARRY_OUT_EN.
- When defined:
  - Adds output port carry (1 bit), valid with out_valid and reset to 0.
  - carry = last bit shifted out. LSL: a[WIDTH-shift]. LSR/ASR: a[shift-1].
  - shift=0 gives carry=0.
  - shift >= WIDTH: LSL/LSR give 0 if shift > WIDTH, otherwise the boundary bit; ASR gives the sign bit.
  - ROR: carry = y[WIDTH-1] when shift mod WIDTH != 0, else 0.
  - carry is pipelined alongside the data with identical latency and stall behaviour.
- When undefined: no carry port, no carry logic.

Test Plan (WIDTH=4, STAGES=2, unless stated):
- Basic ops, out_ready=1: a=4'b1011, shift=1, op=LSL -> 2 cycles later out_valid=1, y=4'b0110; then LSR -> 4'b0101, ASR -> 4'b1101, ROR -> 4'b1101.
- Full-rate streaming: 16 back-to-back beats, all a values 0..15 with shift=2, op=LSL -> outputs in order, one per cycle, y=(a<<2)&4'hF. Example: a=4'b0011 -> 4'b1100, a=4'b1111 -> 4'b1100.
- Range limits: a=4'b1000, shift=5 -> LSL 0000, LSR 0000, ASR 1111, ROR 0100. Then shift=0, op=ASR -> y=1000.
- Backpressure: out_ready=0 for 5 cycles with 3 beats sent -> in_ready falls once out_valid=1. No beat lost or duplicated; results emerge in order after out_ready=1.
- Reset mid-flight: accept 2 beats, assert reset for 1 cycle before they emerge -> out_valid=0 immediately and no stale result ever appears. The next beat after reset has latency 2.
- With SHIFTER_CARRY_OUT_EN: a=4'b1001, LSL shift=1 -> y=0010, carry=1. LSR shift=1 -> y=0100, carry=1. shift=0 -> carry=0.
